// File: rtl/led_palette_sequencer_pkg.sv
// Shared types and helpers for the LED palette sequencer: channel modes,
// staggered breathing phase computation and the P-bit to 8-bit expansion.
package led_palette_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_SOLID   = 2'b01,
    LED_BREATHE = 2'b10,
    LED_BLINK   = 2'b11
  } t_led_mode;

  // Start level of channel k: channels are spread evenly down from the top,
  // never below 1 so the triangle stays inside [1, MAX].
  function automatic int f_phase_init(input int k, input int T, input int P);
    int v_max;
    int v_step;
    int v_ph;
    v_max  = (1 << P) - 1;
    v_step = v_max / T;
    v_ph   = v_max - k * v_step;
    return (v_ph < 1) ? 1 : v_ph;
  endfunction

  // Left-align a P-bit level into 8 bits, padding the low bits with ones so
  // a breathing channel never reads as fully off.
  function automatic logic [7:0] f_expand(input logic [7:0] lvl, input int P);
    logic [7:0] v_pad;
    v_pad = 8'((1 << (8 - P)) - 1);
    return 8'(lvl << (8 - P)) | v_pad;
  endfunction

endpackage

// File: rtl/led_palette_sequencer_if.sv
// Mode/mask inputs and duty-value outputs of the palette sequencer, bundled
// so the status logic (master) and the sequencer (slave) share one port.
interface led_palette_sequencer_if #(
  parameter int N = 4,
  parameter int M = 4
);
  localparam int BM_W = (M > 0) ? 2 * M : 1;
  localparam int BL_W = (M > 0) ? 8 * M : 1;

  logic              i_sync;
  logic [2*N-1:0]    i_color_mode;
  logic [3*N-1:0]    i_color_mask;
  logic [BM_W-1:0]   i_basic_mode;
  logic [8*N-1:0]    o_color_led_red_value;
  logic [8*N-1:0]    o_color_led_green_value;
  logic [8*N-1:0]    o_color_led_blue_value;
  logic [BL_W-1:0]   o_basic_led_lumin_value;
  logic              o_step_ce;

  modport master (
    output i_sync, i_color_mode, i_color_mask, i_basic_mode,
    input  o_color_led_red_value, o_color_led_green_value,
           o_color_led_blue_value, o_basic_led_lumin_value, o_step_ce
  );

  modport slave (
    input  i_sync, i_color_mode, i_color_mask, i_basic_mode,
    output o_color_led_red_value, o_color_led_green_value,
           o_color_led_blue_value, o_basic_led_lumin_value, o_step_ce
  );
endinterface

// File: rtl/led_palette_sequencer_triangle_channel.sv
// One breathing channel: a P-bit level bouncing between 1 and MAX, holding
// for one step at each turn, starting from level PH heading down.
module led_triangle_channel
  import led_palette_pkg::*;
#(
  parameter int P  = 6,
  parameter int PH = 63
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  input  logic         i_ce,
  input  logic         i_sync,
  output logic [P-1:0] o_lvl
);

  localparam logic [P-1:0] LV_MAX = '1;
  localparam logic [P-1:0] LV_ONE = P'(1);
  localparam logic [P-1:0] LV_PH  = P'(PH);

  logic [P-1:0] r_lvl;
  logic         r_dir;

  // Triangle walk; resync reloads the start phase and wins over a step.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_lvl <= LV_PH;
      r_dir <= 1'b0;
    end else if (i_sync) begin
      r_lvl <= LV_PH;
      r_dir <= 1'b0;
    end else if (i_ce) begin
      if (r_dir) begin
        if (r_lvl == LV_MAX) r_dir <= 1'b0;
        else                 r_lvl <= r_lvl + 1'b1;
      end else begin
        if (r_lvl == LV_ONE) r_dir <= 1'b1;
        else                 r_lvl <= r_lvl - 1'b1;
      end
    end
  end

  assign o_lvl = r_lvl;

endmodule

// File: rtl/led_palette_sequencer.sv
// Palette sequencer top: step divider, shared blink timing, T breathing
// channels and the registered per-colour duty multiplexer.
module led_palette_sequencer
  import led_palette_pkg::*;
#(
  parameter int parm_color_led_count        = 4,
  parameter int parm_basic_led_count        = 4,
  parameter int parm_FCLK                   = 40_000_000,
  parameter int parm_adjustments_per_second = 128,
  parameter int parm_pulse_bits             = 6,
  parameter int parm_blink_ticks            = 64
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  led_palette_sequencer_if.slave   io_bus
);

  localparam int N     = parm_color_led_count;
  localparam int M     = parm_basic_led_count;
  localparam int T     = N + M;
  localparam int P     = parm_pulse_bits;
  localparam int D     = parm_FCLK / parm_adjustments_per_second;
  localparam int DIV_W = (D > 1) ? $clog2(D) : 1;
  localparam int BT    = parm_blink_ticks;
  localparam int BLK_W = (BT > 1) ? $clog2(BT) : 1;
  localparam int BL_W  = (M > 0) ? 8 * M : 1;

  function automatic logic [7:0] f_duty(input t_led_mode mode, input logic en,
                                        input logic [7:0] breathe, input logic blink);
    logic [7:0] v_duty;
    v_duty = 8'h00;
    if (en) begin
      case (mode)
        LED_SOLID:   v_duty = 8'hFF;
        LED_BREATHE: v_duty = breathe;
        LED_BLINK:   v_duty = blink ? 8'hFF : 8'h00;
        default:     v_duty = 8'h00;
      endcase
    end
    return v_duty;
  endfunction

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_step_ce;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_on;
  logic             w_div_wrap;
  logic [P-1:0]     w_lvl [T];
  logic [7:0]       w_exp [T];
  logic [8*N-1:0]   r_red;
  logic [8*N-1:0]   r_green;
  logic [8*N-1:0]   r_blue;
  logic [BL_W-1:0]  r_lumin;

  assign w_div_wrap = (r_div_cnt == DIV_W'(D - 1));

  // Step divider; a resync restarts the count and drops any pending tick.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_div_cnt <= '0;
      r_step_ce <= 1'b0;
    end else if (io_bus.i_sync) begin
      r_div_cnt <= '0;
      r_step_ce <= 1'b0;
    end else begin
      r_step_ce <= w_div_wrap;
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
    end
  end

  // Blink half-period counter, advanced by step ticks; starts in the on phase.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (io_bus.i_sync) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_step_ce) begin
      if (r_blink_cnt == BLK_W'(BT - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < T; k++) begin : g_ch
    led_triangle_channel #(
      .P  (P),
      .PH (f_phase_init(k, T, P))
    ) u_ch (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_ce     (r_step_ce),
      .i_sync   (io_bus.i_sync),
      .o_lvl    (w_lvl[k])
    );
    assign w_exp[k] = f_expand(8'(w_lvl[k]), P);
  end

  // Colour LED duty registers: mode selects the source, mask gates each colour.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        r_red[8*k +: 8]   <= f_duty(t_led_mode'(io_bus.i_color_mode[2*k +: 2]),
                                    io_bus.i_color_mask[3*k],     w_exp[k], r_blink_on);
        r_green[8*k +: 8] <= f_duty(t_led_mode'(io_bus.i_color_mode[2*k +: 2]),
                                    io_bus.i_color_mask[3*k + 1], w_exp[k], r_blink_on);
        r_blue[8*k +: 8]  <= f_duty(t_led_mode'(io_bus.i_color_mode[2*k +: 2]),
                                    io_bus.i_color_mask[3*k + 2], w_exp[k], r_blink_on);
      end
    end
  end

  if (M > 0) begin : g_basic
    // Basic LED duty registers; these channels follow the colour LEDs.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        r_lumin <= '0;
      end else begin
        for (int k = 0; k < M; k++) begin
          r_lumin[8*k +: 8] <= f_duty(t_led_mode'(io_bus.i_basic_mode[2*k +: 2]),
                                      1'b1, w_exp[N + k], r_blink_on);
        end
      end
    end
  end else begin : g_no_basic
    assign r_lumin = '0;
  end

  assign io_bus.o_color_led_red_value   = r_red;
  assign io_bus.o_color_led_green_value = r_green;
  assign io_bus.o_color_led_blue_value  = r_blue;
  assign io_bus.o_basic_led_lumin_value = r_lumin;
  assign io_bus.o_step_ce               = r_step_ce;

endmodule

// File: tb/tb_led_palette_sequencer.sv
// Bench for led_palette_sequencer: constant-table checks for static modes,
// hand sequences for reset/resync/blink/mode-switch, and randomized traffic,
// all compared each cycle against a closed-form triangle/blink model.
module tb_led_palette_sequencer;

  localparam int N    = 4;
  localparam int M    = 4;
  localparam int T    = N + M;
  localparam int P    = 6;
  localparam int D    = 4;
  localparam int BT   = 2;
  localparam int MAXV = 63;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  // model state: edges since reset/resync, ticks applied, current step_ce
  int   m_cyc;
  int   m_n;
  logic m_ce;

  led_palette_sequencer_if #(.N(N), .M(M)) bus ();

  led_palette_sequencer #(
    .parm_color_led_count        (N),
    .parm_basic_led_count        (M),
    .parm_FCLK                   (64),
    .parm_adjustments_per_second (16),
    .parm_pulse_bits             (P),
    .parm_blink_ticks            (BT)
  ) dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .io_bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmode;
    logic [11:0] cmask;
    logic [7:0]  bmode;
    logic [31:0] e_red;
    logic [31:0] e_green;
    logic [31:0] e_blue;
    logic [31:0] e_lumin;
  } t_vec;

  function automatic int ref_phase(input int k);
    int v;
    v = MAXV - k * (MAXV / T);
    return (v < 1) ? 1 : v;
  endfunction

  // level of channel k after n ticks: position on a 2*MAX-long triangle
  function automatic int ref_lvl(input int k, input int n);
    int i;
    i = (MAXV - ref_phase(k) + n) % (2 * MAXV);
    return (i < MAXV) ? (MAXV - i) : (i - MAXV + 1);
  endfunction

  function automatic logic [7:0] ref_exp(input int lvl);
    return 8'(lvl * 4 + 3);
  endfunction

  function automatic logic [7:0] ref_duty(input logic [1:0] mode, input logic en,
                                          input logic [7:0] br, input logic bl);
    if (!en) return 8'h00;
    case (mode)
      2'd1:    return 8'hFF;
      2'd2:    return br;
      2'd3:    return bl ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_n   = 0;
    m_ce  = 1'b0;
  endtask

  task automatic model_outputs(output logic [31:0] er, output logic [31:0] eg,
                               output logic [31:0] eb, output logic [31:0] el);
    logic       bl;
    logic [1:0] md;
    logic [7:0] e;
    bl = ((m_n / BT) % 2) == 0;
    for (int k = 0; k < N; k++) begin
      md = bus.i_color_mode[2*k +: 2];
      e  = ref_exp(ref_lvl(k, m_n));
      er[8*k +: 8] = ref_duty(md, bus.i_color_mask[3*k],     e, bl);
      eg[8*k +: 8] = ref_duty(md, bus.i_color_mask[3*k + 1], e, bl);
      eb[8*k +: 8] = ref_duty(md, bus.i_color_mask[3*k + 2], e, bl);
    end
    for (int k = 0; k < M; k++) begin
      md = bus.i_basic_mode[2*k +: 2];
      e  = ref_exp(ref_lvl(N + k, m_n));
      el[8*k +: 8] = ref_duty(md, 1'b1, e, bl);
    end
  endtask

  // one clock: predict from pre-edge state and inputs, then compare after the edge
  task automatic tick();
    logic [31:0] er, eg, eb, el;
    logic        nce;
    model_outputs(er, eg, eb, el);
    if (bus.i_sync) begin
      nce   = 1'b0;
      m_cyc = 0;
      m_n   = 0;
    end else begin
      if (m_ce) m_n++;
      nce = ((m_cyc % D) == D - 1);
      m_cyc++;
    end
    m_ce = nce;
    @(posedge clk);
    #1;
    check("red",     bus.o_color_led_red_value,   er);
    check("green",   bus.o_color_led_green_value, eg);
    check("blue",    bus.o_color_led_blue_value,  eb);
    check("lumin",   bus.o_basic_led_lumin_value, el);
    check("step_ce", {31'b0, bus.o_step_ce},      {31'b0, m_ce});
  endtask

  task automatic set_in(input logic [7:0] cm, input logic [11:0] mk, input logic [7:0] bm);
    bus.i_color_mode = cm;
    bus.i_color_mask = mk;
    bus.i_basic_mode = bm;
  endtask

  task automatic check_phases(input string name);
    logic [31:0] er, el;
    for (int k = 0; k < N; k++) er[8*k +: 8] = ref_exp(ref_phase(k));
    for (int k = 0; k < M; k++) el[8*k +: 8] = ref_exp(ref_phase(N + k));
    check(name, bus.o_color_led_red_value, er);
    check(name, bus.o_basic_led_lumin_value, el);
  endtask

  task automatic check_zero(input string name);
    check(name, bus.o_color_led_red_value,   32'h0);
    check(name, bus.o_color_led_green_value, 32'h0);
    check(name, bus.o_color_led_blue_value,  32'h0);
    check(name, bus.o_basic_led_lumin_value, 32'h0);
    check(name, {31'b0, bus.o_step_ce},      32'h0);
  endtask

  initial begin
    t_vec vt [5];
    int   lv, lo, hi;
    logic found;

    vt[0] = '{8'h00, 12'hFFF, 8'h00, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vt[1] = '{8'h55, 12'hFFF, 8'h55, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[2] = '{8'h55, 12'b001_010_100_111, 8'h11,
              32'hFF0000FF, 32'h00FF00FF, 32'h0000FFFF, 32'h00FF00FF};
    vt[3] = '{8'h11, 12'hFFF, 8'h44, 32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF, 32'hFF00FF00};
    vt[4] = '{8'h55, 12'h000, 8'h55, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};

    bus.i_sync = 1'b0;
    set_in(8'hAA, 12'hFFF, 8'hAA);
    model_reset();

    // power-up reset
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    check_phases("pwr_phase");
    repeat (15) tick();

    // static mode/mask table
    for (int i = 0; i < 5; i++) begin
      set_in(vt[i].cmode, vt[i].cmask, vt[i].bmode);
      tick();
      check("tbl_red",   bus.o_color_led_red_value,   vt[i].e_red);
      check("tbl_green", bus.o_color_led_green_value, vt[i].e_green);
      check("tbl_blue",  bus.o_color_led_blue_value,  vt[i].e_blue);
      check("tbl_lumin", bus.o_basic_led_lumin_value, vt[i].e_lumin);
    end

    // channel 0 breathing over a full period plus a little
    set_in(8'hAA, 12'hFFF, 8'hAA);
    lo = 255;
    hi = 0;
    for (int i = 0; i < 130 * D; i++) begin
      tick();
      lv = int'(bus.o_color_led_red_value[7:2]);
      if (lv < lo) lo = lv;
      if (lv > hi) hi = lv;
      check("lvl_range", {31'b0, (lv >= 1 && lv <= MAXV)}, 32'd1);
    end
    check("lvl_min", lo, 32'd1);
    check("lvl_max", hi, 32'd63);

    // LED 1 blinking on red only, aligned by a resync
    set_in(8'b00_00_11_00, 12'b000_000_001_000, 8'h00);
    bus.i_sync = 1'b1;
    tick();
    bus.i_sync = 1'b0;
    repeat (40) tick();

    // resync coincident with a step tick
    set_in(8'hAA, 12'hFFF, 8'hEA);
    repeat (37) tick();
    found = 1'b0;
    for (int i = 0; i < 2 * D && !found; i++) begin
      if (m_ce) found = 1'b1;
      else tick();
    end
    check("sync_tick_found", {31'b0, found}, 32'd1);
    bus.i_sync = 1'b1;
    tick();
    bus.i_sync = 1'b0;
    check("sync_ce_drop", {31'b0, bus.o_step_ce}, 32'd0);
    tick();
    begin
      logic [31:0] er, el;
      for (int k = 0; k < N; k++) er[8*k +: 8] = ref_exp(ref_phase(k));
      for (int k = 0; k < 3; k++) el[8*k +: 8] = ref_exp(ref_phase(N + k));
      el[31:24] = 8'hFF;
      check("sync_red",   bus.o_color_led_red_value,   er);
      check("sync_lumin", bus.o_basic_led_lumin_value, el);
    end

    // basic LED 2 from SOLID to OFF
    set_in(8'hAA, 12'hFFF, 8'h55);
    repeat (2) tick();
    check("solid_lumin", bus.o_basic_led_lumin_value, 32'hFFFFFFFF);
    set_in(8'hAA, 12'hFFF, 8'h45);
    tick();
    check("off_lumin", bus.o_basic_led_lumin_value, 32'hFF00FFFF);

    // asynchronous reset mid-period, then power-up trace again
    set_in(8'hAA, 12'hFFF, 8'hAA);
    repeat (23) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    check_phases("rst_phase");
    repeat (30) tick();

    // randomized modes, masks and occasional resync
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0)
        set_in(8'($urandom), 12'($urandom), 8'($urandom));
      bus.i_sync = ($urandom_range(39) == 0);
      tick();
    end
    bus.i_sync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
